// File: rtl/systemverilog_str_demux.sv
// Byte-stream to bus-packet demux: reassembles 8 stream bytes into one {adr,dat} packet.
// Optional macro SYSTEMVERILOG_STR_DEMUX_PKT_CNT_EN adds a pkt_num transfer counter port.
module systemverilog_str_demux (
  input  logic        clk,
  input  logic        rst,
  input  logic        str_vld,
  input  logic [7:0]  str_bus,
  output logic        str_rdy,
  output logic        bus_vld,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_dat,
  input  logic        bus_rdy
`ifdef SYSTEMVERILOG_STR_DEMUX_PKT_CNT_EN
  ,
  output logic [15:0] pkt_num
`endif
);

  logic [2:0]  byt_cnt_q, byt_cnt_d;
  logic [55:0] asm_q, asm_d;
  logic [63:0] out_q, out_d;
  logic        bus_vld_q, bus_vld_d;
  logic        str_trn, bus_trn, pkt_done;

  // Only the final byte can be refused: it needs the output register to be free.
  assign str_rdy  = ~((byt_cnt_q == 3'd7) & bus_vld_q & ~bus_rdy);
  assign str_trn  = str_vld & str_rdy;
  assign bus_trn  = bus_vld_q & bus_rdy;
  assign pkt_done = str_trn & (byt_cnt_q == 3'd7);

  always_comb begin
    byt_cnt_d = byt_cnt_q;
    asm_d     = asm_q;
    out_d     = out_q;
    bus_vld_d = bus_vld_q;
    if (str_trn) begin
      byt_cnt_d = byt_cnt_q + 3'd1;
    end
    for (int k = 0; k < 7; k++) begin
      if (str_trn && (byt_cnt_q == 3'(k))) begin
        asm_d[8*k +: 8] = str_bus;
      end
    end
    // Completion wins over consumption so a new packet replaces the old with no bubble.
    if (pkt_done) begin
      out_d     = {str_bus, asm_q};
      bus_vld_d = 1'b1;
    end else if (bus_trn) begin
      bus_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      byt_cnt_q <= 3'd0;
      asm_q     <= 56'd0;
      out_q     <= 64'd0;
      bus_vld_q <= 1'b0;
    end else begin
      byt_cnt_q <= byt_cnt_d;
      asm_q     <= asm_d;
      out_q     <= out_d;
      bus_vld_q <= bus_vld_d;
    end
  end

  assign bus_vld = bus_vld_q;
  assign bus_adr = out_q[63:32];
  assign bus_dat = out_q[31:0];

`ifdef SYSTEMVERILOG_STR_DEMUX_PKT_CNT_EN
  logic [15:0] pkt_num_q, pkt_num_d;

  always_comb begin
    pkt_num_d = pkt_num_q;
    if (bus_trn) begin
      pkt_num_d = pkt_num_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_num_q <= 16'd0;
    end else begin
      pkt_num_q <= pkt_num_d;
    end
  end

  assign pkt_num = pkt_num_q;
`endif

endmodule

// File: tb/tb_systemverilog_str_demux.sv
// Bench for systemverilog_str_demux: directed and random stimulus against a queue-based packet model.
module tb_systemverilog_str_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        str_vld = 1'b0;
  logic [7:0]  str_bus = 8'd0;
  logic        bus_rdy = 1'b0;
  logic        str_rdy;
  logic        bus_vld;
  logic [31:0] bus_adr;
  logic [31:0] bus_dat;
`ifdef SYSTEMVERILOG_STR_DEMUX_PKT_CNT_EN
  logic [15:0] pkt_num;
`endif

  systemverilog_str_demux dut (
    .clk    (clk),
    .rst    (rst),
    .str_vld(str_vld),
    .str_bus(str_bus),
    .str_rdy(str_rdy),
    .bus_vld(bus_vld),
    .bus_adr(bus_adr),
    .bus_dat(bus_dat),
    .bus_rdy(bus_rdy)
`ifdef SYSTEMVERILOG_STR_DEMUX_PKT_CNT_EN
    ,
    .pkt_num(pkt_num)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc_n  = 0;
  logic [7:0]  cur[$];
  logic [63:0] pend[$];
  int          trn_q[$];
  logic [15:0] pkt_m = 16'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check outputs, then advance the model past the posedge.
  task automatic cyc(input logic v, input logic [7:0] b, input logic r, input logic rs,
                     output logic acc);
    logic        e_vld, e_rdy, s_trn, b_trn;
    logic [63:0] pk;
    @(negedge clk);
    str_vld = v; str_bus = b; bus_rdy = r; rst = rs;
    #1;
    e_vld = (pend.size() != 0);
    e_rdy = !((cur.size() == 7) && e_vld && !r);
    chk("bus_vld", bus_vld, e_vld);
    chk("str_rdy", str_rdy, e_rdy);
    if (e_vld) begin
      chk("bus_adr", bus_adr, pend[0][63:32]);
      chk("bus_dat", bus_dat, pend[0][31:0]);
    end
`ifdef SYSTEMVERILOG_STR_DEMUX_PKT_CNT_EN
    chk("pkt_num", pkt_num, pkt_m);
`endif
    s_trn = v && e_rdy;
    b_trn = e_vld && r;
    acc   = s_trn && rs;
    @(posedge clk);
    cyc_n++;
    if (!rs) begin
      cur.delete();
      pend.delete();
      pkt_m = 16'd0;
    end else begin
      if (b_trn) begin
        void'(pend.pop_front());
        trn_q.push_back(cyc_n);
        pkt_m++;
      end
      if (s_trn) begin
        cur.push_back(b);
        if (cur.size() == 8) begin
          pk = 64'd0;
          for (int k = 0; k < 8; k++) pk[8*k +: 8] = cur[k];
          pend.push_back(pk);
          cur.delete();
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic r);
    logic acc;
    int   t;
    t = 0;
    do begin
      cyc(1'b1, b, r, 1'b1, acc);
      t++;
    end while (!acc && t < 16);
    chk("send_timeout", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1, 1'b1, acc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic       acc;
    logic [7:0] p1[8];
    logic [7:0] pr[8];

    // Reset held with str_vld=1: nothing may be captured.
    rst = 1'b0; str_vld = 1'b1; str_bus = 8'h5A; bus_rdy = 1'b1;
    @(posedge clk);
    cyc(1'b1, 8'h5A, 1'b1, 1'b0, acc);
    cyc(1'b1, 8'h5A, 1'b1, 1'b0, acc);
    #1;
    chk("rst_adr", bus_adr, 32'h0);
    chk("rst_dat", bus_dat, 32'h0);
    idle(1);

    // Single packet.
    p1 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 8; i++) send_byte(p1[i], 1'b1);
    #1;
    chk("t2_vld", bus_vld, 1'b1);
    chk("t2_dat", bus_dat, 32'h12345678);
    chk("t2_adr", bus_adr, 32'hDEADBEEF);
    idle(2);

    // Backpressure: A pending, B bytes 0..6 accepted, B byte 7 held off.
    for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i), 1'b0);
    for (int i = 0; i < 7; i++) send_byte(8'hB0 + 8'(i), 1'b0);
    cyc(1'b1, 8'hB7, 1'b0, 1'b1, acc);
    chk("t3_hold0", acc, 1'b0);
    cyc(1'b1, 8'hB7, 1'b0, 1'b1, acc);
    chk("t3_hold1", acc, 1'b0);
    send_byte(8'hB7, 1'b1);
    #1;
    chk("t3_b_vld", bus_vld, 1'b1);
    chk("t3_b_adr", bus_adr, 32'hB7B6B5B4);
    chk("t3_b_dat", bus_dat, 32'hB3B2B1B0);
    idle(2);

    // Back-to-back: 4 packets, continuous valid and ready.
    trn_q.delete();
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 8'($urandom), 1'b1, 1'b1, acc);
      chk("t4_acc", acc, 1'b1);
    end
    idle(2);
    chk("t4_ntrn", trn_q.size(), 4);
    for (int i = 1; i < trn_q.size(); i++) chk("t4_gap", trn_q[i] - trn_q[i-1], 8);

    // Reset mid-packet, then a fresh packet.
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), 1'b1);
    cyc(1'b1, 8'hCC, 1'b1, 1'b0, acc);
    pr = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    for (int i = 0; i < 8; i++) send_byte(pr[i], 1'b1);
    #1;
    chk("t5_dat", bus_dat, 32'h04030201);
    chk("t5_adr", bus_adr, 32'h08070605);
    idle(2);
`ifdef SYSTEMVERILOG_STR_DEMUX_PKT_CNT_EN
    cyc(1'b0, 8'h00, 1'b1, 1'b0, acc);
    for (int p = 0; p < 5; p++)
      for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1);
    idle(2);
    #1;
    chk("t6_pkt_num", pkt_num, 16'd5);
`endif

    // Random traffic with random backpressure.
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0, 1'b1, acc);
    idle(3);
    chk("drain_empty", pend.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systemverilog_str_demux.md
Name: systemverilog_str_demux

Overview:
- Downstream counterpart of the bus-to-stream serializer.
- Consumes the 8-bit valid/ready byte stream, reassembles 8 bytes into one t_bus packet (32-bit adr, 32-bit dat) and presents it on a 32-bit valid/ready bus interface.
- Double-buffered: one assembly register plus one output holding register, so byte 0..6 reception of the next packet overlaps a stalled bus output.

Parameters:
- None. Packet format is fixed by package_bus / package_str: t_str is 8 bytes overlaying t_bus.

Ports:
- clk      input   1   system clock, all logic on rising edge
- rst      input   1   reset, synchronous, active-low (asserted when 0)
- str_vld  input   1   stream byte valid
- str_bus  input   8   stream byte
- str_rdy  output  1   stream ready
- bus_vld  output  1   output packet valid
- bus_adr  output  32  packet address
- bus_dat  output  32  packet data
- bus_rdy  input   1   output packet accepted

Behaviour:
- Transfer definitions:
  - str_trn = str_vld & str_rdy
  - bus_trn = bus_vld & bus_rdy
- Byte order (matches the serializer):
  - byte k lands in bits [8k+7:8k] of the 64-bit {adr,dat} overlay.
  - Bytes 0..3 = dat[7:0]..dat[31:24]; bytes 4..7 = adr[7:0]..adr[31:24].
- Byte counter byt_cnt:
  - 3-bit, reset 0, increments on every str_trn, wraps 7 -> 0.
  - On str_trn, str_bus is written into assembly byte byt_cnt.
- Byte 7 (str_trn with byt_cnt==7) completes the packet. In the same edge, the full 64-bit value (assembly bytes 0..6 plus str_bus) is loaded into the output register and bus_vld is set.
- str_rdy (combinational):
  - str_rdy = ~((byt_cnt==7) & bus_vld & ~bus_rdy).
  - Bytes 0..6 are always accepted.
  - Byte 7 is held off only while the output register is occupied and not being consumed this cycle.
- bus_vld next state:
  - Set on packet completion.
  - Else cleared on bus_trn.
  - Else hold.
  - Completion and bus_trn in the same cycle: bus_vld stays 1 and the new packet replaces the old one, giving zero bubble.
- Latency: byte 7 accepted at edge N -> bus_vld=1 and the packet visible on bus_adr/bus_dat from edge N.
- Throughput: 1 packet per 8 clk with continuous str_vld and bus_rdy=1.
- bus_adr/bus_dat:
  - Driven from the output register only.
  - Stable while bus_vld & ~bus_rdy.
- Reset (rst==0 at a clk edge):
  - byt_cnt=0, bus_vld=0.
  - Output and assembly data registers: reset value 0.
  - str_rdy reads 1 from the cycle after reset.
  - A reset mid-packet discards the partial packet and any pending output packet.
  - The first byte after reset release is byte 0.
- Gaps: str_vld low between bytes simply stalls byt_cnt; no timeout.

Optional Feature:
- Macro: SYSTEMVERILOG_STR_DEMUX_PKT_CNT_EN
- Defined:
  - Adds output port pkt_num [15:0] = count of completed bus_trn since reset.
  - Reset 0, +1 per bus_trn, wraps 16'hffff -> 0.
  - Updates at the same edge as the transfer.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
1. Reset: hold rst=0 for 3 clk with str_vld=1 -> bus_vld=0, str_rdy=1 after release, no byte captured during reset.
2. Single packet: bytes 78,56,34,12,EF,BE,AD,DE with bus_rdy=1 -> bus_vld high for exactly 1 clk, bus_dat=32'h12345678, bus_adr=32'hDEADBEEF, valid from the edge accepting byte 7.
3. Backpressure: bus_rdy=0, send packet A then 7 bytes of packet B -> all 7 bytes accepted, str_rdy=0 while B byte 7 is offered, A held stable. Raise bus_rdy -> A consumed, B byte 7 accepted the same cycle, B on bus next cycle with no bubble.
4. Back-to-back: 4 packets with str_vld=1 and bus_rdy=1 continuous -> 4 bus_trn exactly 8 clk apart, all values correct, str_rdy never low.
5. Reset mid-packet: assert rst after byte 3 of a packet, then send a full new packet -> only the new packet appears, with correct byte order.
6. With SYSTEMVERILOG_STR_DEMUX_PKT_CNT_EN: 5 packets -> pkt_num=5. Preload via 65537 packets (or force) -> wrap to 1.
